regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port general register file for the multi-issue pipeline.
- NR combinational read ports and NW write ports.
- Optional same-cycle write-to-read bypass.
- Integrated per-register pending-write scoreboard, so decode sees register-busy status without a separate hazard unit.
- Sits between decode (read/issue side) and writeback (write/release side).

Parameters:
NREG, 32, number of architectural registers; address width AW = clog2(NREG)
DATA_W, 32, register data width
NR, 4, number of read ports
NW, 2, number of write ports, also the number of issue ports
BYPASS, 1, 1 = read returns data written in the same cycle; 0 = read returns the old value
CNT_W, 2, width of each per-register pending-write counter

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset
ra  in  NR*AW  read addresses, port i at ra[i*AW+:AW]
rdata  out  NR*DATA_W  read data, combinational
rbusy  out  NR  read register has pending writes (counter != 0)
we  in  NW  write enables
wa  in  NW*AW  write addresses
wd  in  NW*DATA_W  write data
wrel  in  NW  qualifies we[j]; also releases one pending entry for wa[j]
iss  in  NW  issue strobe: add one pending entry for iss_addr[j]
iss_addr  in  NW*AW  issue destination addresses
sb_err  out  1  sticky scoreboard error flag

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers and counters cleared to 0; sb_err=0.
  - rdata and rbusy then read as 0 for every address.
- Register 0 is hardwired:
  - reads 0 and rbusy=0.
  - writes, issues and releases addressed to 0 are ignored and never set sb_err.
- Write, at posedge clk when we[j]=1 and wa[j]!=0: reg[wa[j]] <= wd[j].
  - Several ports writing the same address in one cycle: highest port index wins.
- Read is combinational from ra[i]:
  - BYPASS=1: if any we[j]=1 with wa[j]==ra[i]!=0 this cycle, rdata[i] = wd of the highest such j; otherwise the stored value.
  - BYPASS=0: always the stored value.
- Scoreboard, counter cnt[r] of CNT_W bits for each r != 0. Each cycle:
  - inc[r] = number of j with iss[j]=1 and iss_addr[j]==r.
  - dec[r] = number of j with we[j]=1, wrel[j]=1 and wa[j]==r.
  - next = cnt + inc - dec, computed in CNT_W+2 signed bits.
  - next > 2^CNT_W - 1: cnt saturates at max; sb_err <= 1.
  - next < 0: cnt clamps at 0; sb_err <= 1.
  - Same-cycle issue and release to the same register cancel (net 0, no error).
  - wrel=1 with we=0 is ignored: no write and no release.
- rbusy[i] = (cnt[ra[i]] != 0), using the registered counter value, with no bypass of same-cycle inc/dec.
  - Rationale: an issue becomes visible to the next cycle's decode; a release clears busy from the next cycle. Write-data bypass covers the release cycle.
- sb_err holds until reset.
- Latency:
  - write to stored value: 1 cycle.
  - bypassed read: 0 cycles.
  - issue/release to rbusy: 1 cycle.
- Reset asserted mid-operation wipes all state immediately. In-flight writebacks after reset deassertion decrement from 0 and set sb_err. This is the expected, documented outcome; the pipeline flushes on reset.
- Out-of-range addresses (>= NREG when NREG is not a power of two): writes and issues ignored, reads return 0 and rbusy=0.

Test Plan:
1. Reset then read all addresses -> rdata=0, rbusy=0, sb_err=0. Write reg5=0xDEADBEEF via port 0 -> read of 5 next cycle = 0xDEADBEEF.
2. Same cycle: port 0 writes r7=0x11, port 1 writes r7=0x22, ra[0]=7 -> rdata[0]=0x22 (BYPASS=1); stored value afterwards 0x22. With BYPASS=0, the same-cycle read returns the old value 0.
3. iss[0]=iss[1]=1 to r3 -> next cycle cnt=2, rbusy=1. Release port 0 -> cnt=1, rbusy=1. Release again -> rbusy=0; sb_err stays 0.
4. Issue r4 four times with CNT_W=2 -> cnt saturates at 3, sb_err=1 from the 4th issue's cycle onward. Release at cnt=0 for r9 -> cnt stays 0.
5. Write, issue and release to r0 with wd=0xFFFFFFFF -> rdata for r0 = 0, rbusy=0, sb_err unchanged.
6. Issue r10 and release r10 in the same cycle with cnt=1 -> cnt stays 1, no error. Then assert reset asynchronously mid-cycle -> cnt, registers and sb_err are 0 before the next clock edge.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback and the multi-port register file.
// The master drives addresses, write data and scoreboard strobes. The slave
// (the register file) returns read data, busy status and the error flag.
interface regfile_mp_if #(
  parameter int NREG   = 32,
  parameter int DATA_W = 32,
  parameter int NR     = 4,
  parameter int NW     = 2
);
  localparam int AW = $clog2(NREG);

  logic [NR*AW-1:0]     ra;
  logic [NR*DATA_W-1:0] rdata;
  logic [NR-1:0]        rbusy;
  logic [NW-1:0]        we;
  logic [NW*AW-1:0]     wa;
  logic [NW*DATA_W-1:0] wd;
  logic [NW-1:0]        wrel;
  logic [NW-1:0]        iss;
  logic [NW*AW-1:0]     iss_addr;
  logic                 sb_err;

  modport master (
    output ra, we, wa, wd, wrel, iss, iss_addr,
    input  rdata, rbusy, sb_err
  );

  modport slave (
    input  ra, we, wa, wd, wrel, iss, iss_addr,
    output rdata, rbusy, sb_err
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with an integrated pending-write scoreboard.
// Register 0 is hardwired to zero and is never busy. Combinational reads,
// optional same-cycle write bypass, and saturating per-register pending counters
// with a sticky error flag for overflow or underflow.
module regfile_mp #(
  parameter int NREG   = 32,
  parameter int DATA_W = 32,
  parameter int NR     = 4,
  parameter int NW     = 2,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 2
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);
  localparam int AW   = $clog2(NREG);
  localparam int CMAX = (1 << CNT_W) - 1;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  cnt_q  [NREG];
  logic [CNT_W-1:0]  cnt_d  [NREG];
  logic              sb_err_q, sb_err_d;

  logic [NR*DATA_W-1:0] rdata_c;
  logic [NR-1:0]        rbusy_c;

  // Address 0 and out-of-range addresses take no part in storage or scoreboard.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREG);
  endfunction

  // Write path: ports are applied in ascending order, so the highest port wins.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NW; j++) begin
      if (bus.we[j] && addr_live(bus.wa[j*AW +: AW])) begin
        regs_d[bus.wa[j*AW +: AW]] = bus.wd[j*DATA_W +: DATA_W];
      end
    end
  end

  // Scoreboard: net issue/release per register, saturating with a sticky error.
  // The net is formed in int, which is wide enough for any inc/dec count.
  always_comb begin
    int inc;
    int dec;
    int nxt;
    inc      = 0;
    dec      = 0;
    nxt      = 0;
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    for (int r = 1; r < NREG; r++) begin
      inc = 0;
      dec = 0;
      for (int j = 0; j < NW; j++) begin
        if (bus.iss[j] && int'(bus.iss_addr[j*AW +: AW]) == r) inc = inc + 1;
        if (bus.we[j] && bus.wrel[j] && int'(bus.wa[j*AW +: AW]) == r) dec = dec + 1;
      end
      nxt = int'(cnt_q[r]) + inc - dec;
      if (nxt > CMAX) begin
        cnt_d[r] = CNT_W'(CMAX);
        sb_err_d = 1'b1;
      end else if (nxt < 0) begin
        cnt_d[r] = '0;
        sb_err_d = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(nxt);
      end
    end
  end

  // State registers; reset wipes contents, counters and the error flag at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  // Read ports: stored value, optionally overridden by a same-cycle write.
  // Busy uses only the registered count, so issues show up one cycle later.
  always_comb begin
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] rd;
    a       = '0;
    rd      = '0;
    rdata_c = '0;
    rbusy_c = '0;
    for (int i = 0; i < NR; i++) begin
      a  = bus.ra[i*AW +: AW];
      rd = '0;
      if (addr_live(a)) begin
        rd = regs_q[a];
        if (BYPASS != 0) begin
          for (int j = 0; j < NW; j++) begin
            if (bus.we[j] && bus.wa[j*AW +: AW] == a) rd = bus.wd[j*DATA_W +: DATA_W];
          end
        end
        rbusy_c[i] = (cnt_q[a] != '0);
      end
      rdata_c[i*DATA_W +: DATA_W] = rd;
    end
  end

  assign bus.rdata  = rdata_c;
  assign bus.rbusy  = rbusy_c;
  assign bus.sb_err = sb_err_q;

endmodule
